// File: rtl/mmio_art_key_pkg.sv
// Shared constants for the ART serial-transmit / key-input bus responder:
// register offsets, status/control bit positions and the TX state encoding.
package mmio_art_key_pkg;

   // Register offsets, taken from bus_address[4:3]
   localparam logic [1:0] OFF_ART_DATA = 2'd0;
   localparam logic [1:0] OFF_ART_STAT = 2'd1;
   localparam logic [1:0] OFF_KEY_DATA = 2'd2;
   localparam logic [1:0] OFF_KEY_CTRL = 2'd3;

   // ART_STAT bit positions
   localparam int STAT_TX_FULL  = 0;
   localparam int STAT_TX_EMPTY = 1;
   localparam int STAT_TX_BUSY  = 2;
   localparam int STAT_TX_OVF   = 3;

   // KEY_CTRL bit positions
   localparam int CTRL_IRQ_EN      = 0;
   localparam int CTRL_RX_NONEMPTY = 1;
   localparam int CTRL_RX_OVF      = 2;

   // Marker bit set in a KEY_DATA read that actually returned a key
   localparam int KEY_VALID_BIT = 8;

   // Serializer states
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/mmio_art_key_responder_if.sv
// Core-side memory-mapped bus: address/data/enables from the core, registered
// read data and the interrupt code back to it.
interface mmio_art_key_responder_if;
   logic [63:0] bus_address;
   logic [63:0] bus_write_data;
   logic        bus_write_enable;
   logic        bus_read_enable;
   logic [63:0] bus_read_data;
   logic [3:0]  interrupt_vector;

   modport master (
      output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
      input  bus_read_data, interrupt_vector
   );

   modport slave (
      input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
      output bus_read_data, interrupt_vector
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. A pop on an empty
// FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot in
// the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage array, written only when a push is actually performed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/mmio_art_key_responder.sv
// Memory-mapped responder: ART serial transmitter at +0x00/+0x08 and key
// input FIFO with interrupt at +0x10/+0x18. Bus transactions are accepted only
// on the rising edge of the write/read enables.
module mmio_art_key_responder
   import mmio_art_key_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          CLK_HZ    = 50_000_000,
   parameter int          BAUD      = 115200,
   parameter int          TX_DEPTH  = 8,
   parameter int          RX_DEPTH  = 8,
   parameter logic [3:0]  IRQ_CODE  = 4'd1
) (
   input  logic                      clk,
   input  logic                      reset,
   mmio_art_key_responder_if.slave   bus,
   input  logic                      key_valid,
   input  logic [7:0]                key_data,
   output logic                      uart_tx
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   // Bus decode and edge qualification
   logic        we_q, re_q;
   logic        hit, wr_acc, rd_acc;
   logic [1:0]  offset;

   // Control/status state
   logic        tx_ovf, tx_ovf_n;
   logic        rx_ovf, rx_ovf_n;
   logic        irq_en, irq_en_n;
   logic [63:0] rd_value;
   logic [63:0] read_data_q;
   logic [3:0]  irq_q;

   // FIFO hookups
   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic        rx_pop, rx_full, rx_empty;
   logic [7:0]  tx_rdata, rx_rdata;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic [$clog2(RX_DEPTH):0] rx_count;

   // Serializer
   tx_state_e   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  sh, sh_n;
   logic        line_q, line_n;
   logic        tx_busy;

   logic        unused_bits;

   assign hit    = (bus.bus_address[63:5] == BASE_ADDR[63:5]);
   assign offset = bus.bus_address[4:3];
   assign wr_acc = bus.bus_write_enable && !we_q && hit;
   assign rd_acc = bus.bus_read_enable  && !re_q && hit;

   assign tx_push = wr_acc && (offset == OFF_ART_DATA);
   assign rx_pop  = rd_acc && (offset == OFF_KEY_DATA) && !rx_empty;
   assign tx_busy = (state != TX_IDLE);

   assign bus.bus_read_data    = read_data_q;
   assign bus.interrupt_vector = irq_q;
   assign uart_tx              = line_q;

   assign unused_bits = ^{bus.bus_write_data[63:8], bus.bus_address[2:0],
                          tx_count, rx_count};

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (bus.bus_write_data[7:0]),
      .rdata (tx_rdata),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (key_valid),
      .pop   (rx_pop),
      .wdata (key_data),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // Register updates from writes and FIFO overflows; reads see post-write values
   always_comb begin
      tx_ovf_n = tx_ovf;
      rx_ovf_n = rx_ovf;
      irq_en_n = irq_en;
      rd_value = '0;
      if (wr_acc && (offset == OFF_ART_STAT) && bus.bus_write_data[3]) tx_ovf_n = 1'b0;
      if (tx_push && tx_full && !tx_pop) tx_ovf_n = 1'b1;
      if (wr_acc && (offset == OFF_KEY_CTRL)) begin
         irq_en_n = bus.bus_write_data[0];
         if (bus.bus_write_data[2]) rx_ovf_n = 1'b0;
      end
      if (key_valid && rx_full && !rx_pop) rx_ovf_n = 1'b1;
      case (offset)
         OFF_ART_STAT: begin
            rd_value[STAT_TX_FULL]  = tx_full;
            rd_value[STAT_TX_EMPTY] = tx_empty;
            rd_value[STAT_TX_BUSY]  = tx_busy;
            rd_value[STAT_TX_OVF]   = tx_ovf_n;
         end
         OFF_KEY_DATA: begin
            if (!rx_empty) begin
               rd_value[7:0]          = rx_rdata;
               rd_value[KEY_VALID_BIT] = 1'b1;
            end
         end
         OFF_KEY_CTRL: begin
            rd_value[CTRL_IRQ_EN]      = irq_en_n;
            rd_value[CTRL_RX_NONEMPTY] = !rx_empty;
            rd_value[CTRL_RX_OVF]      = rx_ovf_n;
         end
         default: rd_value = '0;
      endcase
   end

   // Edge detectors, control registers, read data and interrupt output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         tx_ovf      <= 1'b0;
         rx_ovf      <= 1'b0;
         irq_en      <= 1'b1;
         read_data_q <= '0;
         irq_q       <= 4'd0;
      end else begin
         we_q   <= bus.bus_write_enable;
         re_q   <= bus.bus_read_enable;
         tx_ovf <= tx_ovf_n;
         rx_ovf <= rx_ovf_n;
         irq_en <= irq_en_n;
         if (bus.bus_read_enable && !re_q) read_data_q <= hit ? rd_value : 64'd0;
         irq_q  <= (irq_en && !rx_empty) ? IRQ_CODE : 4'd0;
      end
   end

   // Serializer state register; the line output is registered with the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= TX_IDLE;
         cnt    <= '0;
         idx    <= '0;
         sh     <= '0;
         line_q <= 1'b1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         sh     <= sh_n;
         line_q <= line_n;
      end
   end

   // Serializer next-state: 8N1 framing, each phase lasting DIV clocks
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      tx_pop  = 1'b0;
      line_n  = 1'b1;
      case (state)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop  = 1'b1;
               sh_n    = tx_rdata;
               state_n = TX_START;
               cnt_n   = '0;
            end
         end
         TX_START: begin
            if (cnt == LAST) begin
               state_n = TX_DATA;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               sh_n  = {1'b0, sh[7:1]};
               idx_n = idx + 1'b1;
               if (idx == 3'd7) state_n = TX_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (cnt == LAST) begin
               state_n = TX_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = TX_IDLE;
      endcase
      case (state_n)
         TX_START: line_n = 1'b0;
         TX_DATA:  line_n = sh_n[0];
         default:  line_n = 1'b1;
      endcase
   end
endmodule

// File: doc/mmio_art_key_responder.md
Name: mmio_art_key_responder

Overview:
- Memory-mapped bus responder for the riscv64 core's bus-initiator port (bus_address / bus_write_data / bus_write_enable / bus_read_enable / bus_read_data).
- Implements the ART serial-transmit device at BASE_ADDR+0x00 and the key-input device at BASE_ADDR+0x10.
- Raises interrupt_vector toward the core when key data is pending.
- Sits between the core bus and board pins: uart_tx, key strobe.

Parameters:
- BASE_ADDR, 64'h8000_0000, base of the 32-byte register window.
- CLK_HZ, 50_000_000, clk frequency.
- BAUD, 115200, serial bit rate. DIV = CLK_HZ/BAUD is the number of clk cycles per bit; integer division, truncated.
- TX_DEPTH, 8, TX FIFO entries (power of 2).
- RX_DEPTH, 8, key FIFO entries (power of 2).
- IRQ_CODE, 4'd1, value driven on interrupt_vector when an interrupt is requested.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_address  in  64  byte address from the core
- bus_write_data  in  64  write data; only [7:0] or [3:0] are used, per register
- bus_write_enable  in  1  write request (level)
- bus_read_enable  in  1  read request (level)
- bus_read_data  out  64  registered read data
- interrupt_vector  out  4  IRQ_CODE when an interrupt is requested, else 0
- key_valid  in  1  one-cycle strobe: key_data is valid
- key_data  in  8  key code
- uart_tx  out  1  serial output, 8N1, idle high

Behaviour:
- Decode: a register is hit when bus_address[63:5] == BASE_ADDR[63:5]. Offset = bus_address[4:3]. Misses are ignored; a read miss returns 0.
- Transactions are edge-qualified. A write is accepted only in the cycle bus_write_enable rises (it was low in the previous cycle). A read is likewise accepted only on the rising edge of bus_read_enable. Holding an enable high never repeats a push or pop.
- Read latency: bus_read_data is updated on the clk edge that samples the read rising edge. It holds that value until the next accepted read.
- Write and read rising together at the same address: the write is applied first, then the read.
- Register map:
  - 0x00 ART_DATA
    - Write pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
    - Reads return 0.
  - 0x08 ART_STAT
    - Read returns {60'b0, tx_ovf, tx_busy, tx_empty, tx_full}.
    - Writing wdata[3]=1 clears tx_ovf.
  - 0x10 KEY_DATA
    - Read pops the key FIFO and returns {55'b0, 1'b1, byte}.
    - If the FIFO is empty, the read returns 0 and nothing is popped.
    - Writes are ignored.
  - 0x18 KEY_CTRL
    - Read returns {61'b0, rx_ovf, rx_nonempty, irq_en}.
    - Write: irq_en <= wdata[0]. Writing wdata[2]=1 clears rx_ovf.
- Key input: key_valid pushes key_data into the key FIFO. If the FIFO is full, the byte is dropped and rx_ovf is set.
- FIFO simultaneity: a push and a pop in the same cycle on a full FIFO are both performed (count unchanged). On an empty FIFO the pop is ignored and the push is performed.
- Interrupt: interrupt_vector is registered, = IRQ_CODE when (irq_en && key FIFO non-empty), else 4'd0.
  - It asserts 1 cycle after the push that makes the FIFO non-empty.
  - It deasserts 1 cycle after the pop that empties the FIFO.
- TX serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. When the TX FIFO is non-empty: pop one byte into the shift register and go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA.
  - DATA: send 8 bits LSB first, DIV cycles each. A 3-bit index wraps 7 -> STOP.
  - STOP: uart_tx=1 for DIV cycles, then go to IDLE. The next byte can start in the following cycle.
- tx_busy = (state != IDLE).
- The baud counter counts 0..DIV-1 and restarts on every state change.
- Reset (asynchronous, may arrive mid-frame) forces:
  - uart_tx=1, state IDLE;
  - both FIFOs empty;
  - tx_ovf=rx_ovf=0, irq_en=1;
  - bus_read_data=0, interrupt_vector=0;
  - the edge-detect registers to 0.
- A frame cut by reset is abandoned; there is no retransmission.

Decomposition:
- Package mmio_art_key_pkg holds:
  - register offsets OFF_ART_DATA=0, OFF_ART_STAT=1, OFF_KEY_DATA=2, OFF_KEY_CTRL=3;
  - status bit positions;
  - the TX FSM state encoding.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count; first-word-fall-through read) is instantiated twice, width 8.
- The serializer and bus decode stay in the top module.

Test Plan:
- Reset, then with CLK_HZ=16, BAUD=1 (DIV=16), write 64'h41 to 0x8000_0000 with enable held high for 5 cycles -> exactly one frame on uart_tx: start 0, bits 1,0,0,0,0,0,1,0, stop 1, each 16 cycles; tx_busy=1 during the frame.
- 9 write pulses while the line is busy -> first byte sent, 8 queued, 9th dropped. Reading 0x8000_0008 shows bits 0 and 3 set. Writing 8 to 0x8000_0008 then reading again shows bit 3 clear.
- Pulse key_valid with key_data=8'h31 -> interrupt_vector=1 the next cycle. A read pulse at 0x8000_0010 returns 64'h131 one cycle later, and interrupt_vector returns to 0 the cycle after the pop.
- Read 0x8000_0010 with the key FIFO empty -> returns 0, no underflow. Write 0 to 0x8000_0018, then push a key -> interrupt_vector stays 0; reading 0x8000_0018 returns 64'h2.
- Push key 8'h55 in the same cycle as the read rising edge on a full key FIFO -> count stays 8, rx_ovf=0, the oldest byte is returned.
- Assert reset mid-DATA bit 3 -> uart_tx=1 immediately, FIFOs empty, interrupt_vector=0, irq_en=1; a new write afterwards sends a clean frame.
